// File: rtl/vga_pkg.sv
// Definitions shared by the OV7670 capture block and the VGA display controller.
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    // RGB565 field positions inside a 16-bit pixel word.
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes (high byte first) into one RGB565 pixel.
module ov7670_byte_pair
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  data,
    output logic        pixel_valid,
    output logic [15:0] pixel,
    output logic        pending
);

    logic       phase_low;
    logic [7:0] high_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_low <= 1'b0;
            high_byte <= 8'h00;
        end else if (clear) begin
            phase_low <= 1'b0;
        end else if (byte_en) begin
            if (!phase_low) begin
                high_byte <= data;
            end
            phase_low <= ~phase_low;
        end
    end

    assign pixel_valid = byte_en & phase_low;
    assign pending     = phase_low;

    // The low byte is consumed straight from the input register, so no second holding stage is needed.
    always_comb begin
        pixel              = '0;
        pixel[R_MSB:R_LSB] = high_byte[7:3];
        pixel[G_MSB:G_LSB] = {high_byte[2:0], data[7:5]};
        pixel[B_MSB:B_LSB] = data[4:0];
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: decodes VSYNC/HREF/byte stream into linear frame-buffer writes.
module ov7670_capture
    import vga_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iENABLE,
    input  logic              iVSYNC,
    input  logic              iHREF,
    input  logic [7:0]        iDATA,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [15:0]       oWR_DATA,
    output logic              oFRAME_START,
    output logic              oFRAME_DONE,
    output logic              oFRAME_ERR,
    output logic              oBUSY
);

    localparam int                COL_W     = $clog2(H_ACT + 1);
    localparam int                LINE_W    = $clog2(V_ACT + 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACT);
    localparam logic [COL_W-1:0]  COL_SAT   = '1;
    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(V_ACT);
    localparam logic [LINE_W-1:0] LINE_SAT  = '1;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACT);

    cap_state_t        state;
    logic              vs_q, vs_d, href_q, href_d;
    logic [7:0]        data_q;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] line_base;
    logic              err;

    logic              wr_en, frame_start, frame_done, frame_err, busy;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    logic              capturing, vs_fall, vs_rise, href_fall, start_cond;
    logic              line_end, line_err, byte_en, pair_clear;
    logic              pixel_valid, pending;
    logic [15:0]       pixel;
    logic [COL_W-1:0]  col_inc;
    logic [LINE_W-1:0] line_inc, line_next;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vs_q   <= 1'b0;
            vs_d   <= 1'b0;
            href_q <= 1'b0;
            href_d <= 1'b0;
            data_q <= 8'h00;
        end else begin
            vs_q   <= iVSYNC;
            vs_d   <= vs_q;
            href_q <= iHREF;
            href_d <= href_q;
            data_q <= iDATA;
        end
    end

    assign capturing  = (state == CAPTURE);
    assign vs_fall    = vs_d & ~vs_q;
    assign vs_rise    = ~vs_d & vs_q;
    assign href_fall  = href_d & ~href_q;
    assign start_cond = (state == WAIT_VS_LOW) & iENABLE & vs_fall;
    // A VSYNC rise that cuts off an active line closes that line first.
    assign line_end   = capturing & (href_fall | (vs_rise & href_q));
    assign line_err   = (col != COL_END) | pending;
    assign byte_en    = capturing & href_q & ~vs_rise;
    assign pair_clear = start_cond | line_end;
    assign col_inc    = (col == COL_SAT) ? col : col + 1'b1;
    assign line_inc   = (line == LINE_SAT) ? line : line + 1'b1;
    assign line_next  = line_end ? line_inc : line;

    ov7670_byte_pair u_byte_pair (
        .clk         (iCLK),
        .rst         (iRST),
        .clear       (pair_clear),
        .byte_en     (byte_en),
        .data        (data_q),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .pending     (pending)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            col         <= '0;
            line        <= '0;
            line_base   <= '0;
            err         <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (iENABLE) begin
                        state <= WAIT_VS_HIGH;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VS_HIGH: begin
                    if (!iENABLE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_q) begin
                        state <= WAIT_VS_LOW;
                    end
                end
                WAIT_VS_LOW: begin
                    if (!iENABLE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_fall) begin
                        state       <= CAPTURE;
                        frame_start <= 1'b1;
                        col         <= '0;
                        line        <= '0;
                        line_base   <= '0;
                        err         <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= err | (line_end & line_err) | (line_next != LINE_END);
                        state      <= iENABLE ? WAIT_VS_LOW : IDLE;
                        busy       <= iENABLE;
                    end else if (line_end) begin
                        // Base advances by a fixed stride so a malformed line cannot shift later ones.
                        line      <= line_inc;
                        line_base <= line_base + LINE_STEP;
                        col       <= '0;
                        if (line_err) begin
                            err <= 1'b1;
                        end
                    end else if (pixel_valid) begin
                        if ((col < COL_END) && (line < LINE_END)) begin
                            wr_en   <= 1'b1;
                            wr_addr <= line_base + ADDR_W'(col);
                            wr_data <= pixel;
                        end else begin
                            err <= 1'b1;
                        end
                        col <= col_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oWR_EN       = wr_en;
    assign oWR_ADDR     = wr_addr;
    assign oWR_DATA     = wr_data;
    assign oFRAME_START = frame_start;
    assign oFRAME_DONE  = frame_done;
    assign oFRAME_ERR   = frame_err;
    assign oBUSY        = busy;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a 4x3 frame geometry.
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 19;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          iCLK, iRST, iENABLE, iVSYNC, iHREF;
    logic [7:0]    iDATA;
    logic          oWR_EN, oFRAME_START, oFRAME_DONE, oFRAME_ERR, oBUSY;
    logic [AW-1:0] oWR_ADDR;
    logic [15:0]   oWR_DATA;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;
    int   dones_seen = 0;
    int   writes_seen = 0;
    int   extra_writes = 0;
    logic last_done_err = 1'b0;
    int   line_pix[3];
    bit   odd_byte[3];

    ov7670_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iENABLE      (iENABLE),
        .iVSYNC       (iVSYNC),
        .iHREF        (iHREF),
        .iDATA        (iDATA),
        .oWR_EN       (oWR_EN),
        .oWR_ADDR     (oWR_ADDR),
        .oWR_DATA     (oWR_DATA),
        .oFRAME_START (oFRAME_START),
        .oFRAME_DONE  (oFRAME_DONE),
        .oFRAME_ERR   (oFRAME_ERR),
        .oBUSY        (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_wr_en"},   32'(oWR_EN), 0);
        checkOutput({tag, "_wr_addr"}, 32'(oWR_ADDR), 0);
        checkOutput({tag, "_wr_data"}, 32'(oWR_DATA), 0);
        checkOutput({tag, "_start"},   32'(oFRAME_START), 0);
        checkOutput({tag, "_done"},    32'(oFRAME_DONE), 0);
        checkOutput({tag, "_err"},     32'(oFRAME_ERR), 0);
        checkOutput({tag, "_busy"},    32'(oBUSY), 0);
    endtask

    task automatic set_geometry(input int p0, input int p1, input int p2,
                                input bit o0, input bit o1, input bit o2);
        line_pix[0] = p0;
        line_pix[1] = p1;
        line_pix[2] = p2;
        odd_byte[0] = o0;
        odd_byte[1] = o1;
        odd_byte[2] = o2;
    endtask

    // Drives one whole frame (VSYNC fall, three lines, VSYNC rise); expectations are pushed as low bytes go out.
    task automatic applyStimulus(input bit cap, input int en_line, input int dis_line,
                                 input int rst_line, input bit exp_err);
        int         s0 = starts_seen;
        int         d0 = dones_seen;
        int         w0 = writes_seen;
        int         x0 = extra_writes;
        int         exp_w = 0;
        bit         live = cap;
        logic [7:0] b = 8'h12;
        logic [7:0] hi;
        wr_t        e;
        @(negedge iCLK);
        iVSYNC = 1'b0;
        repeat (3) @(negedge iCLK);
        for (int l = 0; l < 3; l++) begin
            if (l == en_line)  iENABLE = 1'b1;
            if (l == dis_line) iENABLE = 1'b0;
            if (l == rst_line) begin
                #2 iRST = 1'b1;
                #1 check_reset_outputs("mid_frame_rst");
                live = 1'b0;
                @(negedge iCLK);
                iRST = 1'b0;
            end
            for (int p = 0; p < line_pix[l]; p++) begin
                iHREF = 1'b1;
                iDATA = b;
                hi    = b;
                b     = b + 8'h22;
                @(negedge iCLK);
                iDATA = b;
                if (live && p < H) begin
                    e.addr = AW'(l * H + p);
                    e.data = {hi, b};
                    exp_q.push_back(e);
                    exp_w++;
                end
                b = b + 8'h22;
                @(negedge iCLK);
            end
            if (odd_byte[l]) begin
                iHREF = 1'b1;
                iDATA = b;
                b     = b + 8'h22;
                @(negedge iCLK);
            end
            iHREF = 1'b0;
            iDATA = 8'h00;
            repeat (4) @(negedge iCLK);
        end
        iVSYNC = 1'b1;
        repeat (6) @(negedge iCLK);
        checkOutput("start_count", starts_seen - s0, 32'(cap));
        checkOutput("done_count", dones_seen - d0, 32'(cap && rst_line < 0));
        if (cap && rst_line < 0) checkOutput("frame_err", 32'(last_done_err), 32'(exp_err));
        checkOutput("write_count", writes_seen - w0, exp_w);
        checkOutput("extra_writes", extra_writes - x0, 0);
        checkOutput("pending_expected", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : monitor
        wr_t m;
        forever begin
            @(posedge iCLK);
            #1;
            if (oFRAME_START) starts_seen++;
            if (oFRAME_DONE) begin
                dones_seen++;
                last_done_err = oFRAME_ERR;
            end
            if (oWR_EN) begin
                writes_seen++;
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(oWR_ADDR), 32'(m.addr));
                    checkOutput("wr_data", 32'(oWR_DATA), 32'(m.data));
                end else begin
                    extra_writes++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        iRST    = 1'b1;
        iENABLE = 1'b0;
        iVSYNC  = 1'b1;
        iHREF   = 1'b0;
        iDATA   = 8'h00;
        repeat (3) @(negedge iCLK);
        check_reset_outputs("por");
        iRST = 1'b0;
        @(negedge iCLK);
        iENABLE = 1'b1;
        repeat (4) @(negedge iCLK);
        checkOutput("busy_enabled", 32'(oBUSY), 1);
        #2 iRST = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (4) @(negedge iCLK);

        $display("[TB] nominal frame");
        set_geometry(4, 4, 4, 0, 0, 0);
        applyStimulus(1, -1, -1, -1, 0);

        $display("[TB] enable mid-frame");
        iENABLE = 1'b0;
        repeat (3) @(negedge iCLK);
        applyStimulus(0, 1, -1, -1, 0);
        applyStimulus(1, -1, -1, -1, 0);

        $display("[TB] short line");
        set_geometry(4, 3, 4, 0, 0, 0);
        applyStimulus(1, -1, -1, -1, 1);

        $display("[TB] overlong line with trailing byte");
        set_geometry(4, 5, 4, 0, 1, 0);
        applyStimulus(1, -1, -1, -1, 1);
        set_geometry(4, 4, 4, 0, 0, 0);
        applyStimulus(1, -1, -1, -1, 0);

        $display("[TB] disable mid-capture then reset mid-frame");
        set_geometry(4, 3, 4, 0, 0, 0);
        applyStimulus(1, -1, 1, -1, 1);
        checkOutput("busy_after_disable", 32'(oBUSY), 0);
        set_geometry(4, 4, 4, 0, 0, 0);
        applyStimulus(0, -1, -1, -1, 0);
        iENABLE = 1'b1;
        repeat (4) @(negedge iCLK);
        applyStimulus(1, -1, -1, 1, 0);
        applyStimulus(1, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
